// File: rtl/otbn_imem_responder_if.sv
// OTBN IMEM responder bus bundle: core fetch port, host port and wipe control.
interface otbn_imem_responder_if #(
  parameter int unsigned ImemAddrWidth = 12
);
  logic                     imem_req_i;
  logic [ImemAddrWidth-1:0] imem_addr_i;
  logic [38:0]              imem_rdata_o;
  logic                     imem_rvalid_o;

  logic                     host_req_i;
  logic                     host_we_i;
  logic [ImemAddrWidth-1:0] host_addr_i;
  logic [31:0]              host_wdata_i;
  logic                     host_gnt_o;
  logic [38:0]              host_rdata_o;
  logic                     host_rvalid_o;

  logic                     core_busy_i;
  logic                     wipe_req_i;
  logic                     wipe_busy_o;
  logic                     wipe_done_o;

  modport slave (
    input  imem_req_i, imem_addr_i, host_req_i, host_we_i, host_addr_i, host_wdata_i,
           core_busy_i, wipe_req_i,
    output imem_rdata_o, imem_rvalid_o, host_gnt_o, host_rdata_o, host_rvalid_o,
           wipe_busy_o, wipe_done_o
  );

  modport master (
    output imem_req_i, imem_addr_i, host_req_i, host_we_i, host_addr_i, host_wdata_i,
           core_busy_i, wipe_req_i,
    input  imem_rdata_o, imem_rvalid_o, host_gnt_o, host_rdata_o, host_rvalid_o,
           wipe_busy_o, wipe_done_o
  );
endinterface

// File: rtl/otbn_imem_responder.sv
// OTBN instruction memory responder: word array with integrity, core/host
// arbitration by core busy state, and a sequential whole-array wipe.
module otbn_imem_responder #(
  parameter int unsigned ImemSizeByte = 4096
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  otbn_imem_responder_if.slave  bus
);
  localparam int unsigned ImemAddrWidth = (ImemSizeByte <= 1) ? 1 : $clog2(ImemSizeByte);
  localparam int unsigned Depth         = ImemSizeByte / 4;
  localparam int unsigned IdxW          = ImemAddrWidth - 2;
  localparam logic [38:0] WipeWord      = 39'h2A00000000;

  typedef enum logic {
    StIdle = 1'b0,
    StWipe = 1'b1
  } state_e;

  // Inverted 39/32 SECDED encoder; the inversion keeps all-zero words illegal.
  function automatic logic [38:0] secded_inv_enc(input logic [31:0] d);
    logic [38:0] c;
    c     = 39'(d);
    c[32] = ^(c & 39'h002606BD25);
    c[33] = ^(c & 39'h00DEBA8050);
    c[34] = ^(c & 39'h00413D89AA);
    c[35] = ^(c & 39'h0031234ED1);
    c[36] = ^(c & 39'h00C2C1323B);
    c[37] = ^(c & 39'h002DCC624C);
    c[38] = ^(c & 39'h0098505586);
    return c ^ 39'h2A00000000;
  endfunction

  state_e          r_state;
  logic [IdxW-1:0] r_wipe_cnt;
  logic [38:0]     r_mem [Depth];
  logic [38:0]     r_imem_rdata;
  logic [38:0]     r_host_rdata;
  logic            r_imem_rvalid;
  logic            r_host_rvalid;
  logic            r_wipe_busy;
  logic            r_wipe_done;

  logic [IdxW-1:0] w_core_idx;
  logic [IdxW-1:0] w_host_idx;
  logic            w_core_oor;
  logic            w_host_oor;
  logic            w_idle;
  logic            w_host_gnt;
  logic            w_core_gnt;
  logic            w_host_rd;
  logic            w_host_wr;
  logic            w_unused_addr;

  assign w_core_idx    = bus.imem_addr_i[ImemAddrWidth-1:2];
  assign w_host_idx    = bus.host_addr_i[ImemAddrWidth-1:2];
  assign w_core_oor    = ({1'b0, w_core_idx} >= (IdxW+1)'(Depth));
  assign w_host_oor    = ({1'b0, w_host_idx} >= (IdxW+1)'(Depth));
  assign w_unused_addr = ^{bus.imem_addr_i[1:0], bus.host_addr_i[1:0]};

  // A wipe request pre-empts any access in the same cycle.
  assign w_idle     = (r_state == StIdle) && !bus.wipe_req_i;
  assign w_host_gnt = w_idle && !bus.core_busy_i && bus.host_req_i;
  assign w_core_gnt = w_idle && bus.imem_req_i && (bus.core_busy_i || !bus.host_req_i);
  assign w_host_rd  = w_host_gnt && !bus.host_we_i;
  assign w_host_wr  = w_host_gnt && bus.host_we_i && !w_host_oor;

  // Storage array, deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (r_state == StWipe) begin
      r_mem[r_wipe_cnt] <= WipeWord;
    end else if (w_host_wr) begin
      r_mem[w_host_idx] <= secded_inv_enc(bus.host_wdata_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= StIdle;
      r_wipe_cnt    <= '0;
      r_imem_rdata  <= '0;
      r_host_rdata  <= '0;
      r_imem_rvalid <= 1'b0;
      r_host_rvalid <= 1'b0;
      r_wipe_busy   <= 1'b0;
      r_wipe_done   <= 1'b0;
    end else begin
      r_imem_rvalid <= w_core_gnt;
      r_host_rvalid <= w_host_rd;
      r_wipe_done   <= 1'b0;
      if (w_core_gnt) begin
        r_imem_rdata <= w_core_oor ? '0 : r_mem[w_core_idx];
      end
      if (w_host_rd) begin
        r_host_rdata <= w_host_oor ? '0 : r_mem[w_host_idx];
      end
      case (r_state)
        StIdle: begin
          if (bus.wipe_req_i) begin
            r_state     <= StWipe;
            r_wipe_cnt  <= '0;
            r_wipe_busy <= 1'b1;
          end
        end
        StWipe: begin
          if (r_wipe_cnt == IdxW'(Depth - 1)) begin
            r_state     <= StIdle;
            r_wipe_busy <= 1'b0;
            r_wipe_done <= 1'b1;
          end else begin
            r_wipe_cnt <= r_wipe_cnt + IdxW'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.host_gnt_o    = w_host_gnt;
  assign bus.imem_rdata_o  = r_imem_rdata;
  assign bus.imem_rvalid_o = r_imem_rvalid;
  assign bus.host_rdata_o  = r_host_rdata;
  assign bus.host_rvalid_o = r_host_rvalid;
  assign bus.wipe_busy_o   = r_wipe_busy;
  assign bus.wipe_done_o   = r_wipe_done;

  a_gnt_exclusive: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_host_gnt && w_core_gnt));
  a_rvalid_has_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.imem_rvalid_o |-> $past(w_core_gnt));

endmodule

// File: tb/tb_otbn_imem_responder.sv
// Directed bench for otbn_imem_responder with a reference memory model and
// per-port expected-response queues.
module tb_otbn_imem_responder;
  localparam int unsigned SizeB = 4096;
  localparam int unsigned AW    = 12;
  localparam int unsigned Depth = 1024;
  localparam logic [38:0] ENC0  = 39'h2A00000000;
  localparam logic [31:0] HMASK [7] = '{32'h2606BD25, 32'hDEBA8050, 32'h413D89AA,
                                        32'h31234ED1, 32'hC2C1323B, 32'h2DCC624C,
                                        32'h98505586};

  typedef struct packed {
    logic        v;
    logic [38:0] d;
  } rsp_t;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  otbn_imem_responder_if #(.ImemAddrWidth(AW)) bus();

  otbn_imem_responder #(.ImemSizeByte(SizeB)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  rsp_t        core_q[$];
  rsp_t        host_q[$];
  logic [38:0] mdl [Depth];
  logic [38:0] last_core = '0;
  logic [38:0] last_host = '0;
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic logic [38:0] ref_enc(input logic [31:0] d);
    logic [38:0] w;
    w = {7'b0, d};
    for (int i = 0; i < 7; i++) w[32+i] = ^(d & HMASK[i]);
    return w ^ ENC0;
  endfunction

  function automatic logic [6:0] syndrome(input logic [38:0] cw);
    logic [38:0] x;
    logic [6:0]  s;
    x = cw ^ ENC0;
    for (int i = 0; i < 7; i++) s[i] = (^(x[31:0] & HMASK[i])) ^ x[32+i];
    return s;
  endfunction

  task automatic chk(input string tag, input logic [38:0] obs, input logic [38:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.imem_req_i   = 1'b0;
    bus.imem_addr_i  = '0;
    bus.host_req_i   = 1'b0;
    bus.host_we_i    = 1'b0;
    bus.host_addr_i  = '0;
    bus.host_wdata_i = '0;
    bus.wipe_req_i   = 1'b0;
  endtask

  // One normal-mode cycle: predict grants and responses, then check them.
  task automatic tick(input string tag);
    bit          hg, cg, hr;
    logic [9:0]  ci, hi;
    rsp_t        e;
    hg = !bus.wipe_req_i && !bus.core_busy_i && bus.host_req_i;
    cg = !bus.wipe_req_i && bus.imem_req_i && (bus.core_busy_i || !bus.host_req_i);
    hr = hg && !bus.host_we_i;
    ci = bus.imem_addr_i[11:2];
    hi = bus.host_addr_i[11:2];
    #1;
    chk({tag, ":host_gnt"}, 39'(bus.host_gnt_o), 39'(hg));
    if (cg) last_core = mdl[ci];
    e.v = cg; e.d = last_core; core_q.push_back(e);
    if (hr) last_host = mdl[hi];
    e.v = hr; e.d = last_host; host_q.push_back(e);
    if (hg && bus.host_we_i) mdl[hi] = ref_enc(bus.host_wdata_i);
    @(posedge clk_i); #1;
    e = core_q.pop_front();
    chk({tag, ":imem_rvalid"}, 39'(bus.imem_rvalid_o), 39'(e.v));
    chk({tag, ":imem_rdata"}, bus.imem_rdata_o, e.d);
    e = host_q.pop_front();
    chk({tag, ":host_rvalid"}, 39'(bus.host_rvalid_o), 39'(e.v));
    chk({tag, ":host_rdata"}, bus.host_rdata_o, e.d);
    @(negedge clk_i);
  endtask

  // Caller raises wipe_req_i first; counts observed wipe behaviour over a bounded window.
  task automatic run_wipe(input int stop_at, input bit inject,
                          output int busy_n, output int last_busy, output int done_n,
                          output int done_at, output int gnt_n, output int rv_n);
    busy_n = 0; last_busy = -1; done_n = 0; done_at = -1; gnt_n = 0; rv_n = 0;
    for (int c = 0; c <= stop_at; c++) begin
      if (c == 300 && inject) begin
        bus.wipe_req_i  = 1'b1;
        bus.host_req_i  = 1'b1;
        bus.host_addr_i = 12'h040;
        bus.imem_req_i  = 1'b1;
        bus.imem_addr_i = 12'h044;
      end else if (c > 0) begin
        idle_inputs();
      end
      #1;
      if (bus.host_gnt_o) gnt_n++;
      @(posedge clk_i); #1;
      if (bus.wipe_busy_o) begin busy_n++; last_busy = c; end
      if (bus.wipe_done_o) begin done_n++; done_at = c; end
      if (bus.imem_rvalid_o || bus.host_rvalid_o) rv_n++;
      @(negedge clk_i);
    end
    idle_inputs();
  endtask

  initial begin
    int bn, lb, dn, da, gn, rn;
    idle_inputs();
    bus.core_busy_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst:imem_rvalid", 39'(bus.imem_rvalid_o), 39'd0);
    chk("rst:host_rvalid", 39'(bus.host_rvalid_o), 39'd0);
    chk("rst:wipe_busy", 39'(bus.wipe_busy_o), 39'd0);
    chk("rst:wipe_done", 39'(bus.wipe_done_o), 39'd0);
    chk("rst:imem_rdata", bus.imem_rdata_o, 39'd0);
    chk("rst:host_rdata", bus.host_rdata_o, 39'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Host writes then read-back with integrity check.
    bus.host_req_i = 1'b1; bus.host_we_i = 1'b1;
    bus.host_addr_i = 12'h010; bus.host_wdata_i = 32'hDEADBEEF; tick("wr10");
    bus.host_addr_i = 12'h014; bus.host_wdata_i = 32'h0000_0000; tick("wr14");
    bus.host_addr_i = 12'h018; bus.host_wdata_i = $urandom;      tick("wr18");
    bus.host_addr_i = 12'hFFE; bus.host_wdata_i = 32'h0F0F_1234; tick("wrFFC");
    bus.host_we_i = 1'b0; bus.host_addr_i = 12'h010; tick("rd10");
    chk("rd10:data32", 39'(bus.host_rdata_o[31:0]), 39'h0DEADBEEF);
    chk("rd10:syndrome", 39'(syndrome(bus.host_rdata_o)), 39'd0);
    bus.host_addr_i = 12'h014; tick("rd14");
    chk("rd14:enc_zero", bus.host_rdata_o, ENC0);

    // Core owns the memory while busy; held request gives back-to-back data.
    bus.core_busy_i = 1'b1; bus.imem_req_i = 1'b1; bus.imem_addr_i = 12'h010;
    bus.host_addr_i = 12'h018;
    tick("core0"); tick("core1"); tick("core2");
    bus.imem_req_i = 1'b0; tick("core_end"); tick("core_hold");

    // Host wins when core is not busy; core gets in once host drops.
    bus.core_busy_i = 1'b0; bus.imem_req_i = 1'b1; bus.imem_addr_i = 12'h018;
    bus.host_req_i = 1'b1; bus.host_addr_i = 12'h014; tick("arb_host");
    bus.host_req_i = 1'b0; tick("arb_core");
    bus.imem_addr_i = 12'hFFC; tick("arb_core2");
    bus.imem_req_i = 1'b0;

    // Read-after-write on the same word.
    bus.host_req_i = 1'b1; bus.host_we_i = 1'b1; bus.host_addr_i = 12'h01C;
    bus.host_wdata_i = 32'hA5A5_5A5A; tick("raw_wr");
    bus.host_we_i = 1'b0; tick("raw_rd");
    bus.host_we_i = 1'b1; bus.host_addr_i = 12'h020; bus.host_wdata_i = 32'hCAFE_F00D;
    tick("wr20");

    // Wipe pre-empts a coincident host write; a second pulse mid-wipe is ignored.
    bus.host_wdata_i = 32'h1234_5678; bus.wipe_req_i = 1'b1;
    run_wipe(Depth + 5, 1'b1, bn, lb, dn, da, gn, rn);
    chk("wipe:busy_cycles", 39'(bn), 39'(Depth));
    chk("wipe:last_busy", 39'(lb), 39'(Depth - 1));
    chk("wipe:done_count", 39'(dn), 39'd1);
    chk("wipe:done_at", 39'(da), 39'(Depth));
    chk("wipe:host_gnt_seen", 39'(gn), 39'd0);
    chk("wipe:rvalid_seen", 39'(rn), 39'd0);
    for (int i = 0; i < Depth; i++) mdl[i] = ENC0;
    bus.host_req_i = 1'b1; bus.host_addr_i = 12'h020; tick("post_wipe20");
    bus.host_req_i = 1'b0; bus.core_busy_i = 1'b1; bus.imem_req_i = 1'b1;
    bus.imem_addr_i = 12'hFFC; tick("post_wipeFFC");
    bus.imem_req_i = 1'b0; bus.core_busy_i = 1'b0;

    // Repopulate, then reset in the middle of a wipe.
    bus.host_req_i = 1'b1; bus.host_we_i = 1'b1; bus.host_addr_i = 12'hFFC;
    bus.host_wdata_i = 32'h7777_0001; tick("wrFFC_b");
    bus.host_we_i = 1'b0; tick("rdFFC_b");
    bus.wipe_req_i = 1'b1;
    run_wipe(499, 1'b0, bn, lb, dn, da, gn, rn);
    chk("midwipe:busy_cycles", 39'(bn), 39'd500);
    chk("midwipe:done_count", 39'(dn), 39'd0);
    rst_ni = 1'b0;
    #1;
    chk("midwipe_rst:wipe_busy", 39'(bus.wipe_busy_o), 39'd0);
    chk("midwipe_rst:host_rdata", bus.host_rdata_o, 39'd0);
    dn = 0;
    repeat (3) begin
      @(posedge clk_i); #1;
      if (bus.wipe_done_o) dn++;
    end
    chk("midwipe_rst:done_seen", 39'(dn), 39'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    last_core = '0; last_host = '0;
    @(negedge clk_i);
    bus.wipe_req_i = 1'b1;
    run_wipe(Depth + 5, 1'b0, bn, lb, dn, da, gn, rn);
    chk("rewipe:busy_cycles", 39'(bn), 39'(Depth));
    chk("rewipe:done_count", 39'(dn), 39'd1);
    chk("rewipe:done_at", 39'(da), 39'(Depth));
    for (int i = 0; i < Depth; i++) mdl[i] = ENC0;
    bus.host_req_i = 1'b1; bus.host_addr_i = 12'hFFC; tick("rewipe_rdFFC");
    bus.host_addr_i = 12'h010; tick("rewipe_rd10");
    idle_inputs();
    tick("final_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/otbn_imem_responder.md
Name: otbn_imem_responder

Overview:
- Responder end of the OTBN instruction-memory read interface; it serves the fetch unit's prefetch requests.
- Owns a word-organised IMEM storage array, 39 bits per word (32 data + 7 inverted-SECDED integrity).
- Serves two requesters: core fetch (read-only, 1-cycle latency) and host bus (read/write, 1-cycle latency).
- Arbitration follows core busy state. A sequential wipe FSM can overwrite the whole array.

Parameters:
- ImemSizeByte, 4096, IMEM size in bytes; must be a multiple of 4.
- ImemAddrWidth, vbits(ImemSizeByte), localparam; byte-address width.
- Depth, ImemSizeByte/4, localparam; number of words.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- imem_req_i  in  1  core fetch read request
- imem_addr_i  in  ImemAddrWidth  core byte address; bits [1:0] ignored
- imem_rdata_o  out  39  core read data with integrity
- imem_rvalid_o  out  1  core read data valid
- host_req_i  in  1  host access request
- host_we_i  in  1  host write enable
- host_addr_i  in  ImemAddrWidth  host byte address; bits [1:0] ignored
- host_wdata_i  in  32  host write data
- host_gnt_o  out  1  host request accepted this cycle (combinational)
- host_rdata_o  out  39  host read data with integrity
- host_rvalid_o  out  1  host read data valid
- core_busy_i  in  1  OTBN executing; core has exclusive access
- wipe_req_i  in  1  single-cycle pulse: start full-array wipe
- wipe_busy_o  out  1  wipe in progress
- wipe_done_o  out  1  single-cycle pulse when wipe completes

Behaviour:
- Reset values:
  - Outputs: imem_rvalid_o=0, host_rvalid_o=0, wipe_busy_o=0, wipe_done_o=0, imem_rdata_o=0, host_rdata_o=0.
  - FSM state: IDLE.
  - Array contents are not reset.
- Word index = addr[ImemAddrWidth-1:2].
- Host writes:
  - Stored word = prim_secded_inv_39_32_enc(host_wdata_i).
  - Encoding of 32'h0 is 39'h2A00000000.
- FSM IDLE:
  - Arbitration:
    - core_busy_i=1: core access granted if imem_req_i; host_gnt_o=0.
    - core_busy_i=0: host_gnt_o=host_req_i. Core access is granted only if imem_req_i and !host_req_i.
  - Granted read at cycle N: array read at N; rdata/rvalid registered and presented at N+1 for exactly one cycle.
  - Read data is held in rdata_o until the next granted read of that port. rvalid deasserts when there is no grant.
  - Granted host write at N: array updated at the edge ending N; host_rvalid_o stays 0 for writes.
  - Read-after-write: a read at N+1 to the same word returns the new value. Write and read cannot coincide (single port).
  - Core held request: imem_req_i high for k consecutive granted cycles yields rvalid high for k consecutive cycles starting one cycle later. This covers the stalled-fetch re-read of the same address.
- FSM IDLE -> WIPE:
  - Transition on wipe_req_i (takes priority over any access that cycle; that access is not granted).
  - A wipe counter is cleared to 0.
- FSM WIPE:
  - Each cycle writes 39'h2A00000000 to word[counter], then counter++.
  - wipe_busy_o=1. host_gnt_o=0. No core grants. Both rvalids are 0.
  - When counter==Depth-1: write the last word, go to IDLE, pulse wipe_done_o in the first IDLE cycle.
  - Wipe takes exactly Depth cycles.
  - wipe_req_i during WIPE is ignored.
- Reset mid-wipe: FSM returns to IDLE, outputs return to reset values, no done pulse. Partial array contents are undefined.
- Out-of-range addresses (word index >= Depth): not possible when ImemSizeByte is a power of two. Otherwise reads return 0 with rvalid=1, and writes are dropped.
- Assertions:
  - host_gnt_o and core grant are never both asserted.
  - imem_rvalid_o implies the core was granted in the previous cycle.

Test Plan:
- Host write: core_busy_i=0, host writes 32'hDEADBEEF to addr 0x10, then reads 0x10 -> host_rvalid_o=1 one cycle after grant; host_rdata_o[31:0]=32'hDEADBEEF; decoder reports no error.
- Core read: core_busy_i=1, imem_req_i held 3 cycles at addr 0x10 -> imem_rvalid_o high for 3 cycles starting one cycle later, each with data DEADBEEF; host_gnt_o=0 throughout despite host_req_i=1.
- Arbitration: core_busy_i=0, host_req_i=1 and imem_req_i=1 same cycle -> host granted, imem_rvalid_o=0 next cycle; drop host_req_i -> core granted, rvalid next cycle.
- Wipe: Depth=1024, pulse wipe_req_i -> wipe_busy_o high exactly 1024 cycles; wipe_done_o pulses once; any read of addr 0xFFC afterwards returns 39'h2A00000000.
- Reset mid-wipe: assert rst_ni=0 at wipe cycle 500 -> wipe_busy_o=0, no wipe_done_o; a new wipe_req_i restarts the count from 0 and completes in 1024 cycles.
- Wipe preempts access: wipe_req_i coincident with host write to 0x20 -> host_gnt_o=0, write dropped, and 0x20 reads 39'h2A00000000 after the wipe.
